// File: rtl/fft_pkg.sv
// Shared sizes, FSM state type and butterfly address helpers for the FFT address generator.
package fft_pkg;
    localparam int FFT_N  = 64;
    localparam int ADDR_W = 6;
    localparam int TW_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    function automatic logic is_one_hot(input logic [ADDR_W-1:0] s);
        return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
    endfunction

    // Encodes a one-hot span into its bit position, i.e. log2(h).
    function automatic logic [2:0] span_log2(input logic [ADDR_W-1:0] s);
        return {s[4] | s[5], s[2] | s[3], s[1] | s[3] | s[5]};
    endfunction

    // h-1 masks pos out of b; the remaining group bits move up by one to skip the partner half.
    function automatic logic [ADDR_W-1:0] bfly_addr(input logic [ADDR_W-1:0] s,
                                                    input logic [ADDR_W-1:0] c);
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] a;
        mask = s - 6'd1;
        b    = {1'b0, c[5:1]};
        a    = ((b & ~mask) << 3'd1) | (b & mask);
        return c[0] ? (a | s) : a;
    endfunction

    function automatic logic [TW_W-1:0] tw_index(input logic [ADDR_W-1:0] s,
                                                 input logic [ADDR_W-1:0] c);
        logic [ADDR_W-1:0] pos;
        logic [2:0]        sh;
        pos = {1'b0, c[5:1]} & (s - 6'd1);
        sh  = 3'd5 - span_log2(s);
        return pos[4:0] << sh;
    endfunction
endpackage

// File: rtl/fft_delay_line.sv
// Parameterised DEPTH-stage shift register; reset flushes every stage.
module fft_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Advance the pipeline one stage per clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[DEPTH-1];
endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT read/twiddle/write-back address generator with stage drain tracking.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int WB_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] stage,
    input  logic [ADDR_W-1:0] count,
    input  logic              new_stage,
    input  logic              cnt_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [TW_W-1:0]   tw_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              stage_done,
    output logic              fft_done,
    output logic              err
);
    localparam logic [ADDR_W-1:0] LAST_SPAN = ADDR_W'(FFT_N / 2);

    fsm_state_t        state_r;
    logic [ADDR_W-1:0] stage_q;
    logic [3:0]        idle_cnt_r;
    logic              legal_s;
    logic              issue_s;
    logic              drained_s;
    logic [ADDR_W:0]   wb_s;

    assign legal_s   = is_one_hot(stage);
    assign issue_s   = cnt_en & legal_s;
    // Once WB_LAT idle cycles have passed since the last read, its write has left the pipeline.
    assign drained_s = (idle_cnt_r >= 4'(WB_LAT));

    // Read strobe, address and twiddle registers, cycles-since-last-read counter, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en      <= 1'b0;
            rd_addr    <= 6'd0;
            tw_idx     <= 5'd0;
            idle_cnt_r <= 4'd0;
            err        <= 1'b0;
        end else begin
            rd_en <= issue_s;
            if (issue_s) begin
                rd_addr    <= bfly_addr(stage, count);
                tw_idx     <= tw_index(stage, count);
                idle_cnt_r <= 4'd0;
            end else if (idle_cnt_r != 4'hF) begin
                idle_cnt_r <= idle_cnt_r + 4'd1;
            end
            if (cnt_en && !legal_s) begin
                err <= 1'b1;
            end
        end
    end

    // Stage sequencing FSM with registered completion pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            stage_q    <= 6'd0;
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
        end else begin
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_r <= ST_RUN;
                        stage_q <= stage;
                    end
                end
                ST_RUN: begin
                    if (new_stage || !cnt_en) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!issue_s && drained_s) begin
                        stage_done <= 1'b1;
                        fft_done   <= (stage_q == LAST_SPAN);
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    fft_delay_line #(
        .DEPTH (WB_LAT),
        .WIDTH (ADDR_W + 1)
    ) u_wb_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, rd_addr}),
        .dout (wb_s)
    );

    assign {wr_en, wr_addr} = wb_s;
endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 Parameter: WB_LAT, default 4, write-back latency in cycles from read address to write address (legal 1..8).
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: stage  input  6  one-hot butterfly span h (6'b000001 = h1 ... 6'b100000 = h32).
REQ-005 Port: count  input  6  live count from the stage counter, 0..63.
REQ-006 Port: new_stage  input  1  one-cycle pulse from the stage counter marking count wrap.
REQ-007 Port: cnt_en  input  1  count is live this cycle.
REQ-008 Port: rd_en  output  1  read strobe to sample memory.
REQ-009 Port: rd_addr  output  6  read address.
REQ-010 Port: tw_idx  output  5  twiddle ROM index.
REQ-011 Port: wr_en  output  1  write-back strobe.
REQ-012 Port: wr_addr  output  6  write-back address.
REQ-013 Port: stage_done  output  1  one-cycle pulse, stage fully written back.
REQ-014 Port: fft_done  output  1  one-cycle pulse, last stage (h32) fully written back.
REQ-015 Port: err  output  1  sticky flag, illegal stage seen.

Function
REQ-016 Butterfly index b = count[5:1]; pos = b mod h; group = b div h.
REQ-017 addrA = group*2h + pos; addrB = addrA + h; all arithmetic 6-bit, no wrap possible for legal inputs.
REQ-018 Even count -> rd_addr = addrA; odd count -> rd_addr = addrB.
REQ-019 tw_idx = pos * (32/h), computed from b, identical on the even and odd count of a butterfly.
REQ-020 rd_en/rd_addr/tw_idx registered: appear exactly 1 cycle after the sampled count with cnt_en=1 and one-hot stage.
REQ-021 wr_en/wr_addr = rd_en/rd_addr delayed exactly WB_LAT further cycles via shift pipeline; every read yields exactly one write.
REQ-022 FSM states IDLE, RUN, DRAIN.
REQ-023 IDLE -> RUN on cnt_en=1 with legal stage; stage latched into stage_q.
REQ-024 RUN: new_stage pulse -> DRAIN; cnt_en dropping to 0 -> DRAIN.
REQ-025 DRAIN: wait until write pipeline empty (WB_LAT+1 cycles), then pulse stage_done and return to IDLE; fft_done pulses same cycle iff stage_q = 6'b100000.
REQ-026 cnt_en=1 during DRAIN: reads issued normally (no bubble), DRAIN restarts its empty check; stage_done only once pipeline truly empty.
REQ-027 stage not one-hot (incl. zero) while cnt_en=1: no rd_en for that cycle, err set, held until reset; FSM state unaffected.
REQ-028 new_stage and cnt_en falling on same cycle: single DRAIN, single stage_done.

Reset
REQ-029 rst=0 asynchronously clears all outputs to 0, FSM to IDLE, stage_q to 0, write pipeline flushed.
REQ-030 Reset mid-RUN or mid-DRAIN: no wr_en, stage_done or fft_done emitted for in-flight addresses after release.
REQ-031 First rd_en no earlier than 1 cycle after rst deasserts with cnt_en=1.

Structure
REQ-032 Shared package fft_pkg holds FSM state enum, FFT_N=64, ADDR_W=6, TW_W=5.
REQ-033 One sub-module fft_delay_line (parameterised depth/width shift register) implements the WB_LAT write-back pipeline.
REQ-034 Address/twiddle math uses mask/shift on one-hot stage only; no multipliers or dividers.

Verification
REQ-035 stage=000001, count 0,1,2,3 with cnt_en=1 -> rd_addr 0,1,2,3 one cycle later; tw_idx 0 throughout.
REQ-036 stage=001000, count 2,3 -> rd_addr 1,9, tw_idx 4; count 16,17 -> rd_addr 16,24, tw_idx 0.
REQ-037 stage=100000, count 62,63 -> rd_addr 31,63, tw_idx 31; full 0..63 run -> 64 wr_en exactly WB_LAT cycles behind rd_en, then stage_done and fft_done together.
REQ-038 stage=000101 with cnt_en=1 -> no rd_en, err=1 held through later legal stages until rst=0.
REQ-039 rst=0 at count 20 of stage 000100 -> all outputs 0 immediately; after release no stale wr_en, no stage_done.
REQ-040 new_stage then cnt_en held high into next stage count 0 -> continuous rd_en, stage_done only after the last write of the previous stage drains.
